mem_io_bus: RTL and testbench

MEM_IO_BUS -- requirements
Module: mem_io_bus

---
 rtl/mem_io_bus.sv | 99 +++++++++
 tb/tb_mem_io_bus.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_io_bus.sv
// Nibble-wide memory/IO bus: RAM, sticky interrupt factors with masks, and R/W config nibbles.
// Define MEM_IO_BUS_RDCLR_EN to make factor reads destructive; otherwise factors are write-one-to-clear.
module mem_io_bus #(
  parameter int RAM_DEPTH  = 640,
  parameter int NUM_GROUPS = 3,
  parameter int NUM_CFG    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [11:0]             mem_addr,
  input  logic                    mem_read_en,
  input  logic                    mem_write_en,
  input  logic [3:0]              mem_write_data,
  output logic [3:0]              mem_read_data,
  output logic                    mem_read_valid,
  input  logic [4*NUM_GROUPS-1:0] event_in,
  output logic [4*NUM_CFG-1:0]    cfg_out,
  output logic [NUM_GROUPS-1:0]   irq_out
);
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic                         rd_req, wr_req, is_ram, fpage, mpage, cpage;
  logic [3:0]                   idx;
  logic [3:0]                   rd_d, rd_q;
  logic                         vld_q;
  logic [NUM_GROUPS-1:0][3:0]   factor_q, factor_d, mask_q, mask_d;
  logic [NUM_CFG-1:0][3:0]      cfg_q, cfg_d;
  logic [NUM_GROUPS-1:0]        irq_q, irq_d;
  logic [3:0]                   ram_q [RAM_DEPTH];

  // A write wins over a simultaneous read; the read is dropped entirely.
  assign rd_req = mem_read_en & ~mem_write_en;
  assign wr_req = mem_write_en;
  assign is_ram = mem_addr < 12'(RAM_DEPTH);
  assign fpage  = mem_addr[11:4] == 8'hF0;
  assign mpage  = mem_addr[11:4] == 8'hF1;
  assign cpage  = mem_addr[11:4] == 8'hF2;
  assign idx    = mem_addr[3:0];

  always_ff @(posedge clk) begin
    if (!reset && wr_req && is_ram) ram_q[mem_addr[AW-1:0]] <= mem_write_data;
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    logic       sel_f;
    logic [3:0] clr;
    assign sel_f = fpage && (idx == 4'(g));
`ifdef MEM_IO_BUS_RDCLR_EN
    assign clr = (rd_req && sel_f) ? 4'hF : 4'h0;
`else
    assign clr = (wr_req && sel_f) ? mem_write_data : 4'h0;
`endif
    // Events are OR'd in after the clear so a same-cycle event survives.
    assign factor_d[g] = (factor_q[g] & ~clr) | event_in[4*g +: 4];
    assign mask_d[g]   = (wr_req && mpage && (idx == 4'(g))) ? mem_write_data : mask_q[g];
    assign irq_d[g]    = |(factor_q[g] & mask_q[g]);
  end

  for (genvar c = 0; c < NUM_CFG; c++) begin : g_cfg
    assign cfg_d[c] = (wr_req && cpage && (idx == 4'(c))) ? mem_write_data : cfg_q[c];
  end

  always_comb begin
    rd_d = 4'h0;
    if (rd_req) begin
      if (is_ram) rd_d = ram_q[mem_addr[AW-1:0]];
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (fpage && (idx == 4'(g))) rd_d = factor_q[g];
        if (mpage && (idx == 4'(g))) rd_d = mask_q[g];
      end
      for (int c = 0; c < NUM_CFG; c++) begin
        if (cpage && (idx == 4'(c))) rd_d = cfg_q[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      factor_q <= '0;
      mask_q   <= '0;
      cfg_q    <= '0;
      irq_q    <= '0;
      rd_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      factor_q <= factor_d;
      mask_q   <= mask_d;
      cfg_q    <= cfg_d;
      irq_q    <= irq_d;
      rd_q     <= rd_d;
      vld_q    <= rd_req;
    end
  end

  assign mem_read_data  = rd_q;
  assign mem_read_valid = vld_q;
  assign cfg_out        = cfg_q;
  assign irq_out        = irq_q;
endmodule

// File: tb/tb_mem_io_bus.sv
// Self-checking bench for mem_io_bus: vector table through a read scoreboard, plus irq/clear/reset sequences.
module tb_mem_io_bus;
  localparam int NG = 3;
  localparam int NC = 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic [11:0]   mem_addr = '0;
  logic          mem_read_en = 1'b0, mem_write_en = 1'b0;
  logic [3:0]    mem_write_data = '0;
  logic [3:0]    mem_read_data;
  logic          mem_read_valid;
  logic [4*NG-1:0] event_in = '0;
  logic [4*NC-1:0] cfg_out;
  logic [NG-1:0] irq_out;

  mem_io_bus #(.RAM_DEPTH(640), .NUM_GROUPS(NG), .NUM_CFG(NC)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .event_in(event_in), .cfg_out(cfg_out), .irq_out(irq_out));

  always #5 clk = ~clk;

  typedef struct { logic v; logic [3:0] d; } rsp_t;
  typedef struct {
    logic rd; logic wr; logic [11:0] addr; logic [3:0] wd;
    logic ev; logic [3:0] ed; string nm;
  } vec_t;

  rsp_t sb[$];
  vec_t vt[18];
  int   errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, expectation queued, response popped just after the edge.
  task automatic cycle(input logic rd, input logic wr, input logic [11:0] a, input logic [3:0] wd,
                       input logic [4*NG-1:0] ev, input logic ev_v, input logic [3:0] ev_d,
                       input string nm);
    rsp_t r;
    @(negedge clk);
    mem_read_en = rd; mem_write_en = wr; mem_addr = a; mem_write_data = wd; event_in = ev;
    sb.push_back('{v: ev_v, d: ev_d});
    @(posedge clk); #1;
    mem_read_en = 0; mem_write_en = 0; event_in = '0;
    r = sb.pop_front();
    chk({nm, "_valid"}, int'(mem_read_valid), int'(r.v));
    chk({nm, "_data"}, int'(mem_read_data), int'(r.d));
  endtask

  task automatic idle_chk_irq(input logic [NG-1:0] exp, input string nm);
    cycle(0, 0, 12'h0, 4'h0, '0, 0, 4'h0, nm);
    chk({nm, "_irq"}, int'(irq_out), int'(exp));
  endtask

  initial begin
    vt[0]  = '{1, 0, 12'h27F, 4'h0, 0, 4'h0, "ram_pre"};
    vt[0]  = '{0, 1, 12'h27F, 4'hA, 0, 4'h0, "wr_27f"};
    vt[1]  = '{1, 0, 12'h27F, 4'h0, 1, 4'hA, "rd_27f"};
    vt[2]  = '{1, 0, 12'h280, 4'h0, 1, 4'h0, "rd_280"};
    vt[3]  = '{0, 1, 12'hF23, 4'h5, 0, 4'h0, "wr_cfg3"};
    vt[4]  = '{1, 0, 12'hF23, 4'h0, 1, 4'h5, "rd_cfg3"};
    vt[5]  = '{0, 1, 12'hF20, 4'h3, 0, 4'h0, "wr_cfg0"};
    vt[6]  = '{1, 0, 12'hF20, 4'h0, 1, 4'h3, "rd_cfg0"};
    vt[7]  = '{0, 1, 12'hF28, 4'h7, 0, 4'h0, "wr_cfg8"};
    vt[8]  = '{1, 0, 12'hF28, 4'h0, 1, 4'h0, "rd_cfg8"};
    vt[9]  = '{0, 1, 12'hF13, 4'hF, 0, 4'h0, "wr_mask3"};
    vt[10] = '{1, 0, 12'hF13, 4'h0, 1, 4'h0, "rd_mask3"};
    vt[11] = '{1, 1, 12'h010, 4'h9, 0, 4'h0, "rdwr_010"};
    vt[12] = '{1, 0, 12'h010, 4'h0, 1, 4'h9, "rd_010"};
    vt[13] = '{0, 0, 12'h010, 4'h0, 0, 4'h0, "idle"};
    vt[14] = '{1, 0, 12'hABC, 4'h0, 1, 4'h0, "rd_unmapped"};
    vt[15] = '{0, 1, 12'h000, 4'hF, 0, 4'h0, "wr_000"};
    vt[16] = '{1, 0, 12'h000, 4'h0, 1, 4'hF, "rd_000"};
    vt[17] = '{0, 1, 12'hF10, 4'h4, 0, 4'h0, "wr_mask0"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(mem_read_valid), 0);
    chk("rst_data", int'(mem_read_data), 0);
    chk("rst_cfg", int'(cfg_out), 0);
    chk("rst_irq", int'(irq_out), 0);
    @(negedge clk); reset = 0;

    foreach (vt[i])
      cycle(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, '0, vt[i].ev, vt[i].ed, vt[i].nm);
    cycle(1, 0, 12'hF10, 4'h0, '0, 1, 4'h4, "rd_mask0");
    chk("cfg3_out", int'(cfg_out[15:12]), 5);
    chk("cfg0_out", int'(cfg_out[3:0]), 3);
    chk("cfg8_ignored", int'(cfg_out[31:16]), 0);

    // Unmasked event bit: factor set, irq stays low
    cycle(0, 0, 12'h0, 4'h0, 12'h002, 0, 4'h0, "ev1");
    idle_chk_irq(3'b000, "ev1_a");
    idle_chk_irq(3'b000, "ev1_b");
    // Masked event bit: irq two edges after the pulse
    cycle(0, 0, 12'h0, 4'h0, 12'h004, 0, 4'h0, "ev2");
    chk("ev2_irq_early", int'(irq_out), 0);
    idle_chk_irq(3'b001, "ev2_a");

`ifdef MEM_IO_BUS_RDCLR_EN
    cycle(1, 0, 12'hF00, 4'h0, '0, 1, 4'h6, "fac_rd1");
    cycle(1, 0, 12'hF00, 4'h0, '0, 1, 4'h0, "fac_rd2");
    // Clearing read with a same-cycle event on bit 1: returns pre-edge value
    cycle(1, 0, 12'hF00, 4'h0, 12'h002, 1, 4'h0, "fac_race");
`else
    cycle(1, 0, 12'hF00, 4'h0, '0, 1, 4'h6, "fac_rd1");
    cycle(1, 0, 12'hF00, 4'h0, '0, 1, 4'h6, "fac_rd2");
    cycle(0, 1, 12'hF00, 4'h2, '0, 0, 4'h0, "fac_w1c");
    cycle(1, 0, 12'hF00, 4'h0, '0, 1, 4'h4, "fac_rd3");
    // W1C of bits 2,1 with a same-cycle event on bit 1
    cycle(0, 1, 12'hF00, 4'h6, 12'h002, 0, 4'h0, "fac_race");
`endif
    cycle(1, 0, 12'hF00, 4'h0, '0, 1, 4'h2, "fac_race_rd");

    // Drive irq high via bit 1 before the reset test
    cycle(0, 0, 12'h0, 4'h0, 12'h002, 0, 4'h0, "ev1_again");
    cycle(0, 1, 12'hF10, 4'h2, '0, 0, 4'h0, "wr_mask0_2");
    idle_chk_irq(3'b001, "irq_before_rst");

    // Reset lands between a read request and its response edge
    begin
      int pulses = 0;
      @(negedge clk);
      mem_read_en = 1; mem_addr = 12'hF23;
      #2 reset = 1;
      #1 mem_read_en = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (mem_read_valid) pulses++;
      end
      chk("rst_mid_read_pulses", pulses, 0);
      chk("rst_mid_cfg", int'(cfg_out), 0);
      chk("rst_mid_irq", int'(irq_out), 0);
      @(negedge clk); reset = 0;
    end
    cycle(1, 0, 12'hF23, 4'h0, '0, 1, 4'h0, "rd_cfg3_after_rst");
    cycle(1, 0, 12'hF10, 4'h0, '0, 1, 4'h0, "rd_mask0_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
